// File: rtl/serial_mode_pkg.sv
// -----------------------------------------------------------------------------
// serial_mode_pkg
// Shared definitions for the serial window sequencer:
//   - FSM state encodings (IDLE, RUN, WAIT, DONE)
//   - clog2_min1(): ceiling log2 clamped to a minimum of 1, used to size the
//     window row/column counters so a 1-wide dimension still gets a real bit.
// -----------------------------------------------------------------------------
package serial_mode_pkg;

    localparam int STATE_W = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Number of bits needed to index 'value' items, never less than 1.
    function automatic int clog2_min1(input int value);
        int width;
        width = 0;
        for (int w = 0; w < 31; w++) begin
            if ((32'sd1 <<< w) < value) begin
                width = w + 1;
            end else begin
                width = width;
            end
        end
        if (width < 1) begin
            width = 1;
        end else begin
            width = width;
        end
        return width;
    endfunction

endpackage

// File: rtl/window_addr_gen.sv
// -----------------------------------------------------------------------------
// window_addr_gen
// Combinational base-address generator for one window of the sweep:
//   addr = (BASE_ADDR + row*STRIDE*FM_W + col*STRIDE) mod 2^ADDR_W
// The sum is formed in a widened datapath and then truncated, so an address
// that runs past the top of the ADDR_W space wraps silently.
// Ports:
//   row_i  [ROW_W-1:0]  : window row index
//   col_i  [COL_W-1:0]  : window column index
//   addr_o [ADDR_W-1:0] : feature base address of window (row_i, col_i)
// -----------------------------------------------------------------------------
module window_addr_gen
    import serial_mode_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int FM_W      = 4,
    parameter int STRIDE    = 1,
    parameter int BASE_ADDR = 9,
    parameter int ROW_W     = 1,
    parameter int COL_W     = 1
) (
    input  logic [ROW_W-1:0]  row_i,
    input  logic [COL_W-1:0]  col_i,
    output logic [ADDR_W-1:0] addr_o
);

    // Wide enough that no partial product or sum can overflow before truncation.
    localparam int WIDE_W = ADDR_W + ROW_W + COL_W
                          + clog2_min1(STRIDE + 1) + clog2_min1(FM_W + 1) + 1;

    localparam logic [WIDE_W-1:0] ROW_PITCH = WIDE_W'(STRIDE * FM_W);
    localparam logic [WIDE_W-1:0] COL_PITCH = WIDE_W'(STRIDE);
    localparam logic [WIDE_W-1:0] BASE_WIDE = WIDE_W'(BASE_ADDR);

    // Widened address sum, truncated to ADDR_W (modulo wrap).
    always_comb begin
        addr_o = ADDR_W'(BASE_WIDE
                         + (WIDE_W'(row_i) * ROW_PITCH)
                         + (WIDE_W'(col_i) * COL_PITCH));
    end

endmodule

// File: rtl/serial_window_sequencer.sv
// -----------------------------------------------------------------------------
// serial_window_sequencer
// Steps a compute engine through an OUT_ROWS x OUT_COLS grid of windows in
// row-major order, one window per is_done_i handshake, then signals sweep
// completion.  FSM: IDLE -> RUN (one cycle per window or longer) -> WAIT (1)
// -> DONE (1) -> IDLE.  i_abort in RUN/WAIT returns to IDLE without a
// completion pulse; rst overrides everything.
// All outputs are registered; each is computed from the next state so it is
// valid in the same cycle the state register enters that state.
// Ports:
//   clk               : clock, rising edge
//   rst               : synchronous active-high reset
//   i_run_serial_mode : start request (sampled in IDLE only)
//   i_abort           : cancel the sweep (RUN/WAIT only)
//   is_done_i         : engine finished the current window (RUN only)
//   en                : engine enable, high in RUN
//   feature_baseaddr  : base address of current window, 0 outside RUN
//   win_row / win_col : current window indices, held outside RUN
//   win_start_o       : pulse on the first cycle of each window
//   busy              : high in every state except IDLE
//   is_done_o         : one-cycle sweep-complete pulse (DONE state)
// -----------------------------------------------------------------------------
module serial_window_sequencer
    import serial_mode_pkg::*;
#(
    parameter int  ADDR_W    = 8,
    parameter int  FM_W      = 4,
    parameter int  OUT_ROWS  = 2,
    parameter int  OUT_COLS  = 2,
    parameter int  STRIDE    = 1,
    parameter int  BASE_ADDR = 9,
    localparam int ROW_W     = clog2_min1(OUT_ROWS),
    localparam int COL_W     = clog2_min1(OUT_COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_run_serial_mode,
    input  logic              i_abort,
    input  logic              is_done_i,
    output logic              en,
    output logic [ADDR_W-1:0] feature_baseaddr,
    output logic [ROW_W-1:0]  win_row,
    output logic [COL_W-1:0]  win_col,
    output logic              win_start_o,
    output logic              busy,
    output logic              is_done_o
);

    generate
        if ((OUT_ROWS < 1) || (OUT_COLS < 1) || (STRIDE < 1)) begin : g_param_check
            $error("serial_window_sequencer: OUT_ROWS, OUT_COLS and STRIDE must all be >= 1");
        end
    endgenerate

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               win_start_d;
    logic               last_win_s;
    logic [ADDR_W-1:0]  addr_s;

    logic               en_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               win_start_q;
    logic               busy_q;
    logic               done_q;

    assign last_win_s = (row_q == ROW_LAST) && (col_q == COL_LAST);

    // Address of the window the counters will point at next cycle.
    window_addr_gen #(
        .ADDR_W    (ADDR_W),
        .FM_W      (FM_W),
        .STRIDE    (STRIDE),
        .BASE_ADDR (BASE_ADDR),
        .ROW_W     (ROW_W),
        .COL_W     (COL_W)
    ) u_addr_gen (
        .row_i  (row_d),
        .col_i  (col_d),
        .addr_o (addr_s)
    );

    // Next-state, window-counter and window-start decisions.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        win_start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_run_serial_mode) begin
                    state_d     = ST_RUN;
                    row_d       = {ROW_W{1'b0}};
                    col_d       = {COL_W{1'b0}};
                    win_start_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Abort wins over a same-cycle completion.
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (is_done_i) begin
                    if (last_win_s) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d     = ST_RUN;
                        win_start_d = 1'b1;
                        // Row-major advance: wrap the column, bump the row.
                        if (col_q == COL_LAST) begin
                            col_d = {COL_W{1'b0}};
                            row_d = row_q + ROW_ONE;
                        end else begin
                            col_d = col_q + COL_ONE;
                            row_d = row_q;
                        end
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; outputs decode the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_q       <= {ROW_W{1'b0}};
            col_q       <= {COL_W{1'b0}};
            en_q        <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            win_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            en_q        <= (state_d == ST_RUN);
            addr_q      <= (state_d == ST_RUN) ? addr_s : {ADDR_W{1'b0}};
            win_start_q <= win_start_d;
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign en               = en_q;
    assign feature_baseaddr = addr_q;
    assign win_row          = row_q;
    assign win_col          = col_q;
    assign win_start_o      = win_start_q;
    assign busy             = busy_q;
    assign is_done_o        = done_q;

endmodule

// File: doc/serial_window_sequencer.md
SERIAL_WINDOW_SEQUENCER -- requirements
Module: serial_window_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8: width of the feature base address.
REQ-002 Parameter FM_W, default 4: feature-map row pitch, in address units.
REQ-003 Parameter OUT_ROWS, default 2: number of window rows; must be >=1.
REQ-004 Parameter OUT_COLS, default 2: number of window columns; must be >=1.
REQ-005 Parameter STRIDE, default 1: window step, applied in both dimensions.
REQ-006 Parameter BASE_ADDR, default 9: address of window (0,0).
REQ-007 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 Port i_run_serial_mode, input, 1 bit: start request, sampled in IDLE only.
REQ-010 Port i_abort, input, 1 bit: cancels the sweep in progress.
REQ-011 Port is_done_i, input, 1 bit: compute engine has finished the current window.
REQ-012 Port en, output, 1 bit: compute engine enable.
REQ-013 Port feature_baseaddr, output, ADDR_W bits: base address of the current window.
REQ-014 Port win_row, output, clog2(OUT_ROWS) bits (minimum 1): current window row.
REQ-015 Port win_col, output, clog2(OUT_COLS) bits (minimum 1): current window column.
REQ-016 Port win_start_o, output, 1 bit: one-cycle pulse on the first cycle of each window.
REQ-017 Port busy, output, 1 bit: high in every state except IDLE.
REQ-018 Port is_done_o, output, 1 bit: one-cycle sweep-complete pulse.

Function
REQ-019 The block SHALL implement states IDLE, RUN, WAIT and DONE.
REQ-020 IDLE SHALL go to RUN in the cycle after i_run_serial_mode=1 is sampled; counters are loaded with row=0, col=0 and win_start_o=1 in that first RUN cycle.
REQ-021 RUN SHALL drive en=1 and feature_baseaddr = (BASE_ADDR + row*STRIDE*FM_W + col*STRIDE) mod 2^ADDR_W.
REQ-022 Address arithmetic SHALL be done at least ADDR_W+clog2 bits wide and then truncated, so the address wraps silently.
REQ-023 is_done_i=1 in RUN, not the last window: advance in row-major order (col+1; at OUT_COLS-1, col=0 and row+1), stay in RUN, pulse win_start_o in the next cycle.
REQ-024 is_done_i=1 in RUN on the last window (row=OUT_ROWS-1, col=OUT_COLS-1): go to WAIT.
REQ-025 is_done_i held high continuously SHALL advance exactly one window per cycle.
REQ-026 WAIT SHALL last one cycle with en=0, then go to DONE.
REQ-027 DONE SHALL last one cycle with is_done_o=1, then go to IDLE.
REQ-028 is_done_i SHALL be ignored in IDLE, WAIT and DONE.
REQ-029 i_run_serial_mode SHALL be ignored outside IDLE.
REQ-030 i_abort=1 in RUN or WAIT SHALL go to IDLE in the next cycle with no is_done_o pulse.
REQ-031 i_abort SHALL take priority over a simultaneous is_done_i.
REQ-032 i_abort in IDLE or DONE SHALL have no effect.
REQ-033 Outside RUN, en=0, feature_baseaddr=0 and win_start_o=0.
REQ-034 All outputs SHALL be fully assigned in every state (no latches).
REQ-035 win_row and win_col SHALL hold their last values outside RUN and reset to 0 in IDLE on start.

Reset
REQ-036 rst=1 SHALL force IDLE and all outputs to 0 on the next edge, including mid-sweep; no is_done_o pulse results.
REQ-037 rst SHALL take priority over i_abort and i_run_serial_mode.

Structure
REQ-038 State encodings and a clog2 helper function SHALL live in the shared package serial_mode_pkg.
REQ-039 The address computation SHALL be one sub-module, window_addr_gen, which is combinational from row and col.
REQ-040 Parameter legality (OUT_ROWS>=1, OUT_COLS>=1, STRIDE>=1) SHALL be checked at elaboration.

Verification
REQ-041 Defaults, is_done_i pulsed 3 cycles after each win_start_o -> addresses 9, 10, 13, 14; is_done_o pulses exactly once, 2 cycles after the 4th is_done_i.
REQ-042 FM_W=8, OUT 3x3, STRIDE=2, BASE_ADDR=0 -> addresses 0, 2, 4, 16, 18, 20, 32, 34, 36 in order; win_row/win_col step 0..2.
REQ-043 BASE_ADDR=253, FM_W=4, ADDR_W=8, 2x2 -> addresses 253, 254, 1, 2 (wrap).
REQ-044 Defaults, is_done_i tied high after start -> four consecutive RUN cycles, then WAIT, DONE, IDLE; total 7 cycles from start sample to IDLE.
REQ-045 i_abort together with is_done_i on the 2nd window -> IDLE next cycle, en=0, no is_done_o; a new i_run_serial_mode restarts at address 9.
REQ-046 rst asserted on the 3rd window -> all outputs 0 next cycle; i_run_serial_mode ignored while rst=1.
